// File: rtl/aud_transport_ctrl.sv
// Transport controller for the Lab3 recorder/player: codec init, record/play/pause/stop over
// N_TRACKS SRAM slots, per-track length, speed level. Macro AUD_LOOP_PLAY_EN enables looped playback.
module aud_transport_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int N_TRACKS  = 4,
  parameter int SPEED_W   = 4,
  parameter int MAX_SPEED = 8,
  localparam int LOG_N    = $clog2(N_TRACKS),
  localparam int SEL_W    = (LOG_N < 1) ? 1 : LOG_N
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic              i_i2c_done,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_speed_up,
  input  logic              i_speed_dn,
  input  logic              i_interp,
  input  logic [SEL_W-1:0]  i_track_sel,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [2:0]        o_state,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [ADDR_W-1:0] o_base_addr,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [SPEED_W-1:0] o_speed,
  output logic              o_fast,
  output logic              o_slow_0,
  output logic              o_slow_1,
  output logic              o_sram_rec_sel,
  output logic              o_sram_we_n
);

  localparam int TRACK_W = ADDR_W - LOG_N;
  localparam int LVL_W   = SPEED_W + 1;
  localparam logic [SEL_W-1:0]  TRACK_MASK = SEL_W'(N_TRACKS - 1);
  localparam logic [ADDR_W-1:0] LO_MASK    = ~({ADDR_W{1'b1}} << TRACK_W);
  localparam logic [TRACK_W:0]  FULL_LEN   = {1'b1, {TRACK_W{1'b0}}};
  localparam logic signed [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_SPEED - 1);
  localparam logic signed [LVL_W-1:0] LVL_MIN = -LVL_MAX;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_RECD       = 3'd2,
    ST_RECD_PAUSE = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5
  } state_t;

  // Handshake: keys are one-cycle request pulses with no back-pressure; every o_*_start/pause/stop
  // strobe is a one-cycle pulse coincident with the first cycle o_state shows the new state.
  state_t            state_q, state_d;
  logic [SEL_W-1:0]  track_q, track_d;
  logic [TRACK_W:0]  len_q [N_TRACKS];
  logic [TRACK_W:0]  len_d [N_TRACKS];
  logic signed [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0]  mag;
  logic [TRACK_W:0]  rec_len;
  logic [ADDR_W-1:0] slot_limit, base_d, end_d;
  logic k_stop, k_pause, k_rec, k_play;
  logic rec_start_d, rec_pause_d, rec_stop_d, dsp_start_d, dsp_pause_d, dsp_stop_d;
`ifdef AUD_LOOP_PLAY_EN
  logic loop_pend_q, loop_pend_d;
`endif

  assign k_stop  = i_key_stop;
  assign k_pause = i_key_pause & ~i_key_stop;
  assign k_rec   = i_key_rec & ~i_key_pause & ~i_key_stop;
  assign k_play  = i_key_play & ~i_key_rec & ~i_key_pause & ~i_key_stop;

  assign slot_limit = o_base_addr | LO_MASK;
  assign rec_len    = (TRACK_W + 1)'(i_rec_addr - o_base_addr) + (TRACK_W + 1)'(1);

  always_comb begin
    state_d     = state_q;
    track_d     = track_q;
    len_d       = len_q;
    level_d     = level_q;
    rec_start_d = 1'b0;
    rec_pause_d = 1'b0;
    rec_stop_d  = 1'b0;
    dsp_start_d = 1'b0;
    dsp_pause_d = 1'b0;
    dsp_stop_d  = 1'b0;
`ifdef AUD_LOOP_PLAY_EN
    loop_pend_d = 1'b0;
`endif
    case (state_q)
      ST_INIT: if (i_i2c_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (k_rec) begin
          len_d[track_q] = '0;
          rec_start_d    = 1'b1;
          state_d        = ST_RECD;
        end else if (k_play && len_q[track_q] != '0) begin
          dsp_start_d = 1'b1;
          state_d     = ST_PLAY;
        end else begin
          track_d = i_track_sel & TRACK_MASK;
        end
      end
      ST_RECD: begin
        len_d[track_q] = rec_len;
        if (k_stop) begin
          rec_stop_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (i_rec_addr == slot_limit) begin
          len_d[track_q] = FULL_LEN;
          rec_stop_d     = 1'b1;
          state_d        = ST_IDLE;
        end else if (k_pause) begin
          rec_pause_d = 1'b1;
          state_d     = ST_RECD_PAUSE;
        end
      end
      ST_RECD_PAUSE: begin
        if (k_stop) begin
          rec_stop_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (k_rec) begin
          rec_start_d = 1'b1;
          state_d     = ST_RECD;
        end
      end
      ST_PLAY: begin
        if (k_stop) begin
          dsp_stop_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (k_pause) begin
          dsp_pause_d = 1'b1;
          state_d     = ST_PLAY_PAUSE;
`ifdef AUD_LOOP_PLAY_EN
        end else if (loop_pend_q) begin
          dsp_start_d = 1'b1;
        // the end check waits out the restart strobe so a stale read address cannot re-trigger it
        end else if (!o_dsp_start && i_play_addr >= o_end_addr) begin
          dsp_stop_d  = 1'b1;
          loop_pend_d = 1'b1;
        end
`else
        end else if (i_play_addr >= o_end_addr) begin
          dsp_stop_d = 1'b1;
          state_d    = ST_IDLE;
        end
`endif
      end
      ST_PLAY_PAUSE: begin
        if (k_stop) begin
          dsp_stop_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (k_play) begin
          dsp_start_d = 1'b1;
          state_d     = ST_PLAY;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (state_q != ST_INIT && state_q != ST_RECD && state_q != ST_RECD_PAUSE) begin
      if (i_speed_up && !i_speed_dn && level_q < LVL_MAX)
        level_d = level_q + LVL_W'(1);
      else if (i_speed_dn && !i_speed_up && level_q > LVL_MIN)
        level_d = level_q - LVL_W'(1);
    end

    mag    = level_d[LVL_W-1] ? LVL_W'(-level_d) : LVL_W'(level_d);
    base_d = ADDR_W'(track_d) << TRACK_W;
    end_d  = base_d + ADDR_W'(len_d[track_d]) - ADDR_W'(1);
  end

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_INIT;
      track_q        <= '0;
      for (int i = 0; i < N_TRACKS; i++) len_q[i] <= '0;
      level_q        <= '0;
      o_rec_start    <= 1'b0;
      o_rec_pause    <= 1'b0;
      o_rec_stop     <= 1'b0;
      o_dsp_start    <= 1'b0;
      o_dsp_pause    <= 1'b0;
      o_dsp_stop     <= 1'b0;
      o_base_addr    <= '0;
      o_end_addr     <= '0;
      o_speed        <= SPEED_W'(1);
      o_fast         <= 1'b0;
      o_slow_0       <= 1'b0;
      o_slow_1       <= 1'b0;
      o_sram_rec_sel <= 1'b0;
      o_sram_we_n    <= 1'b1;
`ifdef AUD_LOOP_PLAY_EN
      loop_pend_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      track_q        <= track_d;
      len_q          <= len_d;
      level_q        <= level_d;
      o_rec_start    <= rec_start_d;
      o_rec_pause    <= rec_pause_d;
      o_rec_stop     <= rec_stop_d;
      o_dsp_start    <= dsp_start_d;
      o_dsp_pause    <= dsp_pause_d;
      o_dsp_stop     <= dsp_stop_d;
      o_base_addr    <= base_d;
      o_end_addr     <= end_d;
      o_speed        <= SPEED_W'(mag) + SPEED_W'(1);
      o_fast         <= level_d > LVL_W'(0);
      o_slow_0       <= level_d[LVL_W-1] & ~i_interp;
      o_slow_1       <= level_d[LVL_W-1] & i_interp;
      o_sram_rec_sel <= (state_d == ST_RECD);
      o_sram_we_n    <= (state_d != ST_RECD);
`ifdef AUD_LOOP_PLAY_EN
      loop_pend_q    <= loop_pend_d;
`endif
    end
  end

  assign o_state = state_q;

endmodule

// File: doc/aud_transport_ctrl.md
Name: aud_transport_ctrl

Overview:
- Parametrised transport controller for the Lab3 recorder/player; it replaces the hand-written control FSM in the top level.
- Sequences I2C init, then record / play / pause / stop over N_TRACKS equal SRAM slots, and keeps a length register per track.
- Manages a signed speed level that drives the DSP fast/slow controls. Arbitrates SRAM direction between the recorder and the DSP.
- All key inputs are single-cycle pulses already synchronised to i_AUD_BCLK.

Parameters:
ADDR_W, 20, SRAM word-address width
N_TRACKS, 4, number of track slots; power of two, >=1
SPEED_W, 4, width of o_speed
MAX_SPEED, 8, maximum speed factor; must be <= 2^SPEED_W-1

Ports:
i_AUD_BCLK  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_i2c_done  in  1  codec init finished (level)
i_key_rec  in  1  record / resume-record pulse
i_key_play  in  1  play / resume-play pulse
i_key_pause  in  1  pause pulse
i_key_stop  in  1  stop pulse
i_speed_up  in  1  speed level +1 pulse
i_speed_dn  in  1  speed level -1 pulse
i_interp  in  1  slow mode select: 0 constant, 1 linear
i_track_sel  in  log2(N_TRACKS) (min 1)  requested track
i_rec_addr  in  ADDR_W  recorder current write address
i_play_addr  in  ADDR_W  DSP current read address
o_state  out  3  0 INIT, 1 IDLE, 2 RECD, 3 RECD_PAUSE, 4 PLAY, 5 PLAY_PAUSE
o_rec_start/o_rec_pause/o_rec_stop  out  1 each  recorder strobes
o_dsp_start/o_dsp_pause/o_dsp_stop  out  1 each  DSP strobes
o_base_addr  out  ADDR_W  active track base address
o_end_addr  out  ADDR_W  base + len - 1 of the active track
o_speed  out  SPEED_W  speed factor, 1..MAX_SPEED
o_fast/o_slow_0/o_slow_1  out  1 each  DSP mode flags
o_sram_rec_sel  out  1  1 = SRAM address/data driven by recorder
o_sram_we_n  out  1  SRAM write enable, active low

Behaviour:
- Clock and reset: i_rst_n is asynchronous and active-low; clock is i_AUD_BCLK.
- Register layout: all outputs registered.
  - Strobes: exactly one cycle wide, asserted the cycle after the triggering transition.
  - TRACK_W = ADDR_W - log2(N_TRACKS).
  - base = track << TRACK_W.
  - Slot limit = base + 2^TRACK_W - 1.
  - len[t] is TRACK_W+1 bits wide.
- Reset values: o_state=INIT, all strobes 0, track=0, all len=0, speed level=0, o_speed=1, o_fast/o_slow_*=0, o_sram_rec_sel=0, o_sram_we_n=1, o_base_addr=0, o_end_addr=0 (all ones when len=0 is handled as below).
- INIT: go to IDLE on i_i2c_done; keys ignored.
- Key priority for same-cycle pulses: stop > pause > rec > play.
- IDLE:
  - Latch i_track_sel every cycle. Track changes are ignored in all other states.
  - rec: clear len[track], pulse o_rec_start, go to RECD.
  - play: if len[track]==0, ignore; else pulse o_dsp_start, go to PLAY.
- RECD:
  - o_sram_rec_sel=1, o_sram_we_n=0 (both registered, so they follow the state).
  - Each cycle, len[track] = i_rec_addr - base + 1.
  - pause: pulse o_rec_pause, go to RECD_PAUSE.
  - stop: pulse o_rec_stop, go to IDLE.
  - i_rec_addr == slot limit: len = 2^TRACK_W, pulse o_rec_stop, go to IDLE (auto-stop on full).
- RECD_PAUSE:
  - rec: pulse o_rec_start, go to RECD.
  - stop: pulse o_rec_stop, go to IDLE.
  - len unchanged.
- PLAY:
  - pause: pulse o_dsp_pause, go to PLAY_PAUSE.
  - stop: pulse o_dsp_stop, go to IDLE.
  - i_play_addr >= o_end_addr: pulse o_dsp_stop, go to IDLE (end of track).
- PLAY_PAUSE:
  - play: pulse o_dsp_start, go to PLAY.
  - stop: pulse o_dsp_stop, go to IDLE.
- Speed level is signed, range -(MAX_SPEED-1)..+(MAX_SPEED-1).
  - up/dn saturate at the range limits. Simultaneous up and dn: no change.
  - Speed keys are ignored in RECD and RECD_PAUSE.
  - o_speed = |level| + 1.
  - o_fast = level > 0.
  - o_slow_0 = level < 0 and !i_interp.
  - o_slow_1 = level < 0 and i_interp.
- Reset mid-operation returns everything to reset values immediately. Track lengths are lost.

Optional Feature:
- Macro: AUD_LOOP_PLAY_EN.
- Defined: end of track in PLAY pulses o_dsp_stop, then o_dsp_start on the following cycle, and stays in PLAY (seamless loop). Only the stop key leaves the loop.
- Undefined: end of track returns to IDLE as described above.

Test Plan:
- Reset, then i_i2c_done=1 -> o_state INIT→IDLE next cycle; o_speed=1, o_sram_we_n=1.
- Track 2 (ADDR_W=20, N_TRACKS=4), rec, i_rec_addr ramps 0x80000..0x8000F, then stop -> o_base_addr=0x80000, len=16, o_end_addr=0x8000F, one o_rec_stop pulse, o_sram_we_n returns to 1.
- Record track 0 until i_rec_addr=0x3FFFF -> auto o_rec_stop, len=0x40000, o_state=IDLE.
- Play track 2, i_play_addr reaches 0x8000F -> o_dsp_stop pulse, IDLE. With AUD_LOOP_PLAY_EN -> o_dsp_stop then o_dsp_start, state stays PLAY.
- Ten i_speed_up pulses -> o_speed=8, o_fast=1 (saturated). Fifteen i_speed_dn with i_interp=1 -> o_speed=8, o_slow_1=1, o_fast=0.
- Same-cycle pause+stop in PLAY -> only o_dsp_stop, IDLE. Play on an empty track -> no strobe, stays IDLE.
